no_lut_node: RTL and testbench

Parametrised Boolean gene-network node for the GNR accelerator: holds `NUM_CH` independent state copies (simulation channels) of one network node. Each channel updates from a `NUM_IN`-input truth table on every `(div+1)`-th start pulse. Updating only on every `(div+1)`-th pulse generalises the fixed "update every start" and "update every second start" timescales into a per-channel programmable divider. Each channel also tracks per-update change and a saturating stability count, so the network controller can detect steady states without reading back every node.

---
 rtl/no_lut_node.sv | 91 +++++++++
 tb/tb_no_lut_node.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/no_lut_node.sv
// Boolean gene-network node: NUM_CH independent state copies, each applying a
// NUM_IN-input truth table on every (div+1)-th start and tracking stability.
module no_lut_node #(
    parameter int NUM_IN     = 3,
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = 4,
    parameter int SC_W       = 4,
    parameter int STABLE_THR = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reset_nos,
    input  logic                     init_state,
    input  logic [(1<<NUM_IN)-1:0]   lut_cfg,
    input  logic [NUM_CH*DIV_W-1:0]  div_cfg,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH*NUM_IN-1:0] in_e,
    output logic [NUM_CH-1:0]        s,
    output logic [NUM_CH-1:0]        node_s,
    output logic [NUM_CH-1:0]        upd,
    output logic [NUM_CH-1:0]        chg,
    output logic [NUM_CH-1:0]        stable
);

    localparam logic [SC_W-1:0] SC_MAX = '1;
    localparam logic [SC_W-1:0] THR    = SC_W'(STABLE_THR);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NUM_IN-1:0] idx;
        logic [DIV_W-1:0]  div;
        logic              nxt;
        logic              changed;
        logic              s_q;
        logic              upd_q;
        logic              chg_q;
        logic [DIV_W-1:0]  ph_q;
        logic [SC_W-1:0]   scnt_q;

        assign idx     = in_e[c*NUM_IN +: NUM_IN];
        assign div     = div_cfg[c*DIV_W +: DIV_W];
        assign nxt     = lut_cfg[idx];
        assign changed = (nxt != s_q);

        // NOTE: every register here sits in the async-reset branch and is
        // written with <= so all channels update from pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q    <= 1'b0;
                upd_q  <= 1'b0;
                chg_q  <= 1'b0;
                ph_q   <= '0;
                scnt_q <= '0;
            end else if (reset_nos) begin
                s_q    <= init_state;
                upd_q  <= 1'b0;
                chg_q  <= 1'b0;
                ph_q   <= '0;
                scnt_q <= '0;
            end else if (start[c]) begin
                if (ph_q == '0) begin
                    // Update step: divider is reloaded only here, so a new
                    // div_cfg never disturbs a countdown already in flight.
                    s_q   <= nxt;
                    ph_q  <= div;
                    upd_q <= 1'b1;
                    chg_q <= changed;
                    if (changed) begin
                        scnt_q <= '0;
                    end else if (scnt_q != SC_MAX) begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end else begin
                    ph_q  <= ph_q - 1'b1;
                    upd_q <= 1'b0;
                    chg_q <= 1'b0;
                end
            end else begin
                upd_q <= 1'b0;
                chg_q <= 1'b0;
            end
        end

        assign s[c]      = s_q;
        assign upd[c]    = upd_q;
        assign chg[c]    = chg_q;
        assign stable[c] = (scnt_q >= THR);
    end

    assign node_s = s;

endmodule

// File: tb/tb_no_lut_node.sv
// Scoreboard bench for no_lut_node: driver queues hand-computed expectations,
// a monitor pops and compares one cycle after every start/reset_nos cycle.
module tb_no_lut_node;

    typedef struct packed {
        logic [1:0] s;
        logic [1:0] upd;
        logic [1:0] chg;
        logic [1:0] stable;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       reset_nos;
    logic       init_state;
    logic [7:0] lut_cfg;
    logic [7:0] div_cfg;
    logic [1:0] start;
    logic [5:0] in_e;
    logic [1:0] s;
    logic [1:0] node_s;
    logic [1:0] upd;
    logic [1:0] chg;
    logic [1:0] stable;

    // Next-vector configuration, applied by step() at the driving edge.
    logic       n_init;
    logic [7:0] n_lut;
    logic [7:0] n_div;
    logic [5:0] n_ine;

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors;
    int    miscompares;
    logic  pend;

    no_lut_node #(
        .NUM_IN(3), .NUM_CH(2), .DIV_W(4), .SC_W(2), .STABLE_THR(3)
    ) dut (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .lut_cfg(lut_cfg), .div_cfg(div_cfg), .start(start), .in_e(in_e),
        .s(s), .node_s(node_s), .upd(upd), .chg(chg), .stable(stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", nm, act, expv);
        end
    endtask

    task automatic step(input logic [1:0] st, input logic rn, input string nm,
                        input logic [1:0] es, input logic [1:0] eu,
                        input logic [1:0] ec, input logic [1:0] est);
        obs_t e;
        @(negedge clk);
        init_state = n_init;
        lut_cfg    = n_lut;
        div_cfg    = n_div;
        in_e       = n_ine;
        start      = st;
        reset_nos  = rn;
        e = {es, eu, ec, est};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        @(negedge clk);
        start     = 2'b00;
        reset_nos = 1'b0;
    endtask

    // Monitor: any cycle carrying start or reset_nos produces one observation.
    always begin
        obs_t  e;
        string nm;
        @(posedge clk);
        pend = !rst && ((|start) || reset_nos);
        @(negedge clk);
        if (pend) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_obs: got s=%b upd=%b with nothing queued", s, upd);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, {s, node_s, upd, chg, stable}, {e.s, e.s, e.upd, e.chg, e.stable});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] xs;
    logic [7:0] xc;

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; reset_nos = 1'b0; init_state = 1'b0; lut_cfg = '0;
        div_cfg = '0; start = '0; in_e = '0;
        n_init = 1'b0; n_lut = '0; n_div = '0; n_ine = '0;
        xs = 8'b1001_0110;   // s[0] for idx 7..0: 1,0,0,1,0,1,1,0
        xc = 8'b1011_1010;   // chg[0] for idx 7..0

        repeat (2) @(negedge clk);
        check("reset_state", {s, node_s, upd, chg, stable}, 10'b0);
        rst = 1'b0;

        // Reload with init_state = 1.
        n_init = 1'b1;
        step(2'b00, 1'b1, "nos_init1", 2'b11, 2'b00, 2'b00, 2'b00);

        // Divider: ch0 div 0, ch1 div 1, all-ones table.
        n_init = 1'b0;
        step(2'b00, 1'b1, "div_nos", 2'b00, 2'b00, 2'b00, 2'b00);
        n_lut = 8'hFF; n_div = {4'd1, 4'd0}; n_ine = '0;
        step(2'b11, 1'b0, "div_1", 2'b11, 2'b11, 2'b11, 2'b00);
        step(2'b11, 1'b0, "div_2", 2'b11, 2'b01, 2'b00, 2'b00);
        step(2'b11, 1'b0, "div_3", 2'b11, 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "div_4", 2'b11, 2'b01, 2'b00, 2'b01);
        idle();
        @(negedge clk);
        check("idle_hold", {2'b00, s, upd, chg, stable}, {2'b00, 8'b11_00_00_01});

        // XOR3 truth-table walk on ch0.
        n_lut = 8'b1001_0110; n_div = '0; n_ine = '0;
        step(2'b00, 1'b1, "xor_nos", 2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++) begin
            n_ine = {3'd0, i[2:0]};
            step(2'b01, 1'b0, $sformatf("xor_idx%0d", i),
                 {1'b0, xs[i]}, 2'b01, {1'b0, xc[i]}, 2'b00);
        end

        // Stability count and saturation (SC_W = 2, threshold 3).
        n_lut = 8'h00; n_ine = '0; n_div = '0;
        step(2'b00, 1'b1, "stab_nos", 2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b11, 1'b0, "stab_1", 2'b00, 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "stab_2", 2'b00, 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "stab_3", 2'b00, 2'b11, 2'b00, 2'b11);
        step(2'b11, 1'b0, "stab_4", 2'b00, 2'b11, 2'b00, 2'b11);
        step(2'b11, 1'b0, "stab_5", 2'b00, 2'b11, 2'b00, 2'b11);
        n_lut = 8'b0000_0001; n_ine = {3'd7, 3'd0};
        step(2'b11, 1'b0, "stab_chg", 2'b01, 2'b11, 2'b01, 2'b10);

        // reset_nos colliding with start while div = 5.
        n_lut = 8'h00; n_ine = '0; n_div = {4'd5, 4'd5};
        step(2'b11, 1'b0, "col_pre", 2'b00, 2'b11, 2'b01, 2'b10);
        n_init = 1'b1;
        step(2'b11, 1'b1, "col_hit", 2'b11, 2'b00, 2'b00, 2'b00);
        n_init = 1'b0;
        step(2'b11, 1'b0, "col_next", 2'b00, 2'b11, 2'b11, 2'b00);

        // Live reconfiguration: div 3 -> 0 while ph = 2.
        n_div = {4'd3, 4'd3};
        step(2'b00, 1'b1, "rcf_nos", 2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b11, 1'b0, "rcf_upd1", 2'b00, 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "rcf_skip1", 2'b00, 2'b00, 2'b00, 2'b00);
        n_div = '0;
        step(2'b11, 1'b0, "rcf_skip2", 2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b11, 1'b0, "rcf_skip3", 2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b11, 1'b0, "rcf_upd2", 2'b00, 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "rcf_upd3", 2'b00, 2'b11, 2'b00, 2'b11);

        // Build up s, upd, stable and a running countdown, then async rst.
        n_lut = 8'hFF;
        step(2'b11, 1'b0, "prerst_1", 2'b11, 2'b11, 2'b11, 2'b00);
        step(2'b11, 1'b0, "prerst_2", 2'b11, 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "prerst_3", 2'b11, 2'b11, 2'b00, 2'b00);
        n_div = {4'd5, 4'd5};
        step(2'b11, 1'b0, "prerst_4", 2'b11, 2'b11, 2'b00, 2'b11);
        @(negedge clk);
        start = 2'b00;
        #2 rst = 1'b1;
        #1 check("async_rst", {s, node_s, upd, chg, stable}, 10'b0);
        @(negedge clk);
        rst = 1'b0;
        n_div = '0;
        step(2'b11, 1'b0, "post_rst", 2'b11, 2'b11, 2'b11, 2'b00);

        idle();
        repeat (2) @(negedge clk);
        check("queue_drained", 10'(exp_q.size()), 10'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
